hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Back-pressure controller for the 5-stage pipeline: the ID/EX register pushes decoded ops forward,
//  this block drives the stall/flush direction back into PC, IF/ID and ID/EX. It detects load-use
//  hazards, flushes on taken branch/jump, and freezes the front end while data memory is busy.
//  It also keeps a wait watchdog and saturating stall/flush statistics counters. It sits beside
//  ID/EX and takes ID-stage and ID/EX-stage fields.
// PARAMETERS
//  MAX_WAIT  16  dmem_busy cycles tolerated before timeout_o sets (>=1)
//  CNT_W     16  width of stall_cnt_o / flush_cnt_o
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_n_i         in   1      asynchronous active-low reset
//  id_rsaddr_i     in   5      rs field of the instruction in ID
//  id_rtaddr_i     in   5      rt field of the instruction in ID
//  id_uses_rt_i    in   1      ID instruction reads rt as a source
//  idex_memread_i  in   1      ID/EX holds a load
//  idex_rtaddr_i   in   5      load destination (rt) held in ID/EX
//  branch_taken_i  in   1      EX resolved taken branch or jump
//  dmem_busy_i     in   1      data memory not ready; EX/MEM/WB hold
//  cnt_clr_i       in   1      sync clear of statistics counters and timeout_o
//  pc_write_o      out  1      1 = PC may update
//  ifid_write_o    out  1      1 = IF/ID may load
//  ifid_flush_o    out  1      1 = IF/ID loads a NOP
//  idex_hold_o     out  1      1 = ID/EX keeps its contents
//  idex_flush_o    out  1      1 = ID/EX loads a bubble (wb/mem/ex = 0)
//  state_o         out  2      0 RUN, 1 MEMWAIT, 2 TIMEOUT
//  timeout_o       out  1      sticky: dmem_busy exceeded MAX_WAIT
//  stall_cnt_o     out  CNT_W  cycles with pc_write_o = 0
//  flush_cnt_o     out  CNT_W  taken-branch flush events
// BEHAVIOUR
//  Reset values: state RUN; counters 0; timeout_o 0. With inputs idle, pc_write_o and ifid_write_o
//   are 1 and the flush/hold outputs are 0.
//  Control outputs are combinational from the current inputs and state, with zero latency. State
//   and counters update on the rising clock edge.
//  ld_use = idex_memread_i & (idex_rtaddr_i != 0) & (idex_rtaddr_i == id_rsaddr_i |
//   (id_uses_rt_i & idex_rtaddr_i == id_rtaddr_i)).
//  Priority, highest first, with exactly one rule applied per cycle:
//   1 dmem_busy_i: pc_write=0, ifid_write=0, idex_hold=1. No flush is applied. A taken branch is
//     held by the frozen EX stage and is applied on the first non-busy cycle.
//   2 branch_taken_i: ifid_flush=1, idex_flush=1, pc_write=1. Any ld_use is discarded because the
//     younger instructions are squashed.
//   3 ld_use: pc_write=0, ifid_write=0, idex_flush=1. This is a single bubble, and the hazard clears
//     by itself the next cycle.
//   4 otherwise: pass (pc_write=1, ifid_write=1).
//  FSM:
//   RUN -> MEMWAIT when dmem_busy_i=1. The wait counter loads 1.
//   MEMWAIT: while busy, wait counter +1. When wait counter == MAX_WAIT with busy still 1 ->
//     TIMEOUT and timeout_o<=1.
//   MEMWAIT/TIMEOUT -> RUN when dmem_busy_i=0. Outputs are released in that same cycle (rule 2-4 apply).
//   TIMEOUT behaves as MEMWAIT except the counter stops. timeout_o stays 1 until cnt_clr_i or reset.
//  stall_cnt_o +1 on every cycle with pc_write_o=0. flush_cnt_o +1 on every cycle rule 2 fires.
//   Both saturate at all-ones and do not wrap.
//  cnt_clr_i zeroes the counters and timeout_o on that edge; the clear wins over the increment in
//   that edge. It does not affect state.
//  Asynchronous reset mid-stall returns everything to reset values immediately.
// TESTING
//  ID/EX lw to $5, ID add reading $5 as rs -> 1 cycle pc_write=0, idex_flush=1; next cycle pass; stall_cnt=1.
//  Load to $0 with ID reading $0 -> no stall.
//  Load to $7 and ID rt=$7 with id_uses_rt=0 -> no stall.
//  ld_use and branch_taken in the same cycle -> flush both (ifid_flush=1, idex_flush=1),
//   pc_write=1, flush_cnt=1, stall_cnt=0.
//  dmem_busy high 3 cycles with branch_taken held -> 3 frozen cycles, then flush on cycle 4;
//   state returns to RUN; stall_cnt=3.
//  MAX_WAIT=4, busy held 6 cycles -> TIMEOUT after the 4th cycle; timeout_o stays 1 after busy
//   drops; cnt_clr_i clears it.
//  CNT_W=2 with 5 stall cycles -> stall_cnt_o stops at 3.
//  rst_n_i low during MEMWAIT -> state RUN and counters 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, dmem-busy freeze, wait watchdog, stats.
// Latency: control outputs are combinational (zero cycles); state, watchdog and counters update on clk_i rise.
// Backpressure: dmem_busy_i freezes PC/IF/ID/ID-EX, load-use inserts one bubble, and a taken branch squashes IF/ID and ID/EX.
//
// Ports:
//   clk_i, rst_n_i                  clock (rising edge), asynchronous active-low reset
//   id_rsaddr_i, id_rtaddr_i        source register fields of the instruction in ID
//   id_uses_rt_i                    ID instruction reads rt as a source
//   idex_memread_i, idex_rtaddr_i   load in ID/EX and its destination register
//   branch_taken_i                  EX resolved a taken branch/jump
//   dmem_busy_i                     data memory not ready
//   cnt_clr_i                       synchronous clear of the statistics counters and timeout_o
//   pc_write_o, ifid_write_o        write enables for PC and IF/ID
//   ifid_flush_o, idex_flush_o      squash IF/ID (NOP) and ID/EX (bubble)
//   idex_hold_o                     ID/EX keeps its contents
//   state_o                         0 RUN, 1 MEMWAIT, 2 TIMEOUT
//   timeout_o                       sticky watchdog flag
//   stall_cnt_o, flush_cnt_o        saturating stall-cycle and flush-event counters
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       id_rsaddr_i,
    input  logic [4:0]       id_rtaddr_i,
    input  logic             id_uses_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rtaddr_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    input  logic             cnt_clr_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_hold_o,
    output logic             idex_flush_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              set_timeout;
    logic              ld_use;
    logic              flush_evt;

    // Register $0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign ld_use = idex_memread_i && (idex_rtaddr_i != 5'd0) &&
                    ((idex_rtaddr_i == id_rsaddr_i) ||
                     (id_uses_rt_i && (idex_rtaddr_i == id_rtaddr_i)));

    // Priority chain: memory freeze, then branch flush, then load-use bubble, then pass.
    // While busy the branch stays in the frozen EX stage and is applied once memory is ready.
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_hold_o  = 1'b0;
        idex_flush_o = 1'b0;
        flush_evt    = 1'b0;
        if (dmem_busy_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_hold_o  = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            flush_evt    = 1'b1;
        end else if (ld_use) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end
    end

    // Watchdog FSM. wait_nxt is the number of consecutive busy cycles including the
    // current one; reaching MAX_WAIT moves to TIMEOUT on this edge.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        set_timeout = 1'b0;
        case (state)
            ST_RUN: begin
                if (dmem_busy_i) begin
                    wait_nxt  = WAIT_ONE;
                    state_nxt = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                if (dmem_busy_i) begin
                    wait_nxt = wait_cnt + WAIT_ONE;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_TIMEOUT: begin
                // Counter is frozen here; only the release matters.
                if (!dmem_busy_i) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        if (dmem_busy_i && (state != ST_TIMEOUT) && (wait_nxt >= MAX_WAIT_V)) begin
            state_nxt   = ST_TIMEOUT;
            set_timeout = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Statistics and sticky timeout; a clear on the same edge beats any increment or set.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            timeout_o   <= 1'b0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            if (!pc_write_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
            if (set_timeout) begin
                timeout_o <= 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl, built with MAX_WAIT=4 and CNT_W=2 so the watchdog and
// counter saturation are reachable in a few cycles.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rsaddr;
    logic [4:0] id_rtaddr;
    logic       id_uses_rt;
    logic       idex_memread;
    logic [4:0] idex_rtaddr;
    logic       branch_taken;
    logic       dmem_busy;
    logic       cnt_clr;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_hold;
    logic       idex_flush;
    logic [1:0] state;
    logic       timeout;
    logic [1:0] stall_cnt;
    logic [1:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.MAX_WAIT(4), .CNT_W(2)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .id_rsaddr_i    (id_rsaddr),
        .id_rtaddr_i    (id_rtaddr),
        .id_uses_rt_i   (id_uses_rt),
        .idex_memread_i (idex_memread),
        .idex_rtaddr_i  (idex_rtaddr),
        .branch_taken_i (branch_taken),
        .dmem_busy_i    (dmem_busy),
        .cnt_clr_i      (cnt_clr),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .idex_hold_o    (idex_hold),
        .idex_flush_o   (idex_flush),
        .state_o        (state),
        .timeout_o      (timeout),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rsaddr    = 5'd0;
        id_rtaddr    = 5'd0;
        id_uses_rt   = 1'b0;
        idex_memread = 1'b0;
        idex_rtaddr  = 5'd0;
        branch_taken = 1'b0;
        dmem_busy    = 1'b0;
        cnt_clr      = 1'b0;
    endtask

    task automatic clear_cnt();
        set_idle();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if (stall_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        n_checks++; if (flush_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        n_checks++; if ({pc_write, ifid_write, ifid_flush, idex_hold, idex_flush} !== 5'b11000) begin
            n_fail++; $display("FAIL reset_idle_ctrl: got %b expected 11000", {pc_write, ifid_write, ifid_flush, idex_hold, idex_flush});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_release_state: got %0d expected 0", state); end
    endtask

    task automatic test_ld_use();
        clear_cnt();
        idex_memread = 1'b1;
        idex_rtaddr  = 5'd5;
        id_rsaddr    = 5'd5;
        id_rtaddr    = 5'd6;
        id_uses_rt   = 1'b1;
        #1;
        n_checks++; if ({pc_write, ifid_write, idex_flush, ifid_flush, idex_hold} !== 5'b00100) begin
            n_fail++; $display("FAIL ld_use_stall: got %b expected 00100", {pc_write, ifid_write, idex_flush, ifid_flush, idex_hold});
        end
        tick();
        // The bubble is now in ID/EX, so the load has moved on.
        idex_memread = 1'b0;
        idex_rtaddr  = 5'd0;
        #1;
        n_checks++; if ({pc_write, ifid_write, idex_flush} !== 3'b110) begin
            n_fail++; $display("FAIL ld_use_release: got %b expected 110", {pc_write, ifid_write, idex_flush});
        end
        n_checks++; if (stall_cnt !== 2'd1) begin n_fail++; $display("FAIL ld_use_stall_cnt: got %0d expected 1", stall_cnt); end
        tick();
        n_checks++; if (stall_cnt !== 2'd1) begin n_fail++; $display("FAIL ld_use_stall_cnt_hold: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_no_stall();
        clear_cnt();
        // Load into $0 with ID reading $0.
        idex_memread = 1'b1;
        idex_rtaddr  = 5'd0;
        id_rsaddr    = 5'd0;
        id_rtaddr    = 5'd0;
        id_uses_rt   = 1'b1;
        #1;
        n_checks++; if ({pc_write, idex_flush} !== 2'b10) begin
            n_fail++; $display("FAIL ld_zero_no_stall: got %b expected 10", {pc_write, idex_flush});
        end
        // Load into $7, ID rt=$7 but rt is not a source.
        idex_rtaddr = 5'd7;
        id_rsaddr   = 5'd3;
        id_rtaddr   = 5'd7;
        id_uses_rt  = 1'b0;
        #1;
        n_checks++; if ({pc_write, idex_flush} !== 2'b10) begin
            n_fail++; $display("FAIL rt_unused_no_stall: got %b expected 10", {pc_write, idex_flush});
        end
        // Same fields, rt now read as a source.
        id_uses_rt = 1'b1;
        #1;
        n_checks++; if ({pc_write, idex_flush} !== 2'b01) begin
            n_fail++; $display("FAIL rt_used_stall: got %b expected 01", {pc_write, idex_flush});
        end
        set_idle();
        tick();
    endtask

    task automatic test_branch_over_ld_use();
        clear_cnt();
        idex_memread = 1'b1;
        idex_rtaddr  = 5'd5;
        id_rsaddr    = 5'd5;
        branch_taken = 1'b1;
        #1;
        n_checks++; if ({pc_write, ifid_flush, idex_flush, idex_hold} !== 4'b1110) begin
            n_fail++; $display("FAIL branch_ld_ctrl: got %b expected 1110", {pc_write, ifid_flush, idex_flush, idex_hold});
        end
        tick();
        set_idle();
        #1;
        n_checks++; if (flush_cnt !== 2'd1) begin n_fail++; $display("FAIL branch_ld_flush_cnt: got %0d expected 1", flush_cnt); end
        n_checks++; if (stall_cnt !== 2'd0) begin n_fail++; $display("FAIL branch_ld_stall_cnt: got %0d expected 0", stall_cnt); end
        tick();
    endtask

    task automatic test_busy_branch();
        clear_cnt();
        dmem_busy    = 1'b1;
        branch_taken = 1'b1;
        #1;
        n_checks++; if ({pc_write, ifid_write, idex_hold, ifid_flush, idex_flush} !== 5'b00100) begin
            n_fail++; $display("FAIL busy_freeze: got %b expected 00100", {pc_write, ifid_write, idex_hold, ifid_flush, idex_flush});
        end
        tick();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL busy_state_memwait: got %0d expected 1", state); end
        tick();
        tick();
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL busy_no_timeout: got %b expected 0", timeout); end
        dmem_busy = 1'b0;
        #1;
        n_checks++; if ({pc_write, ifid_flush, idex_flush, idex_hold} !== 4'b1110) begin
            n_fail++; $display("FAIL busy_release_flush: got %b expected 1110", {pc_write, ifid_flush, idex_flush, idex_hold});
        end
        tick();
        branch_taken = 1'b0;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL busy_state_run: got %0d expected 0", state); end
        n_checks++; if (stall_cnt !== 2'd3) begin n_fail++; $display("FAIL busy_stall_cnt: got %0d expected 3", stall_cnt); end
        n_checks++; if (flush_cnt !== 2'd1) begin n_fail++; $display("FAIL busy_flush_cnt: got %0d expected 1", flush_cnt); end
    endtask

    task automatic test_timeout();
        clear_cnt();
        dmem_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if ({state, timeout} !== 3'b010) begin
                n_fail++; $display("FAIL timeout_wait_%0d: got state=%0d to=%b expected state=1 to=0", i, state, timeout);
            end
        end
        tick();
        n_checks++; if ({state, timeout} !== 3'b101) begin
            n_fail++; $display("FAIL timeout_enter: got state=%0d to=%b expected state=2 to=1", state, timeout);
        end
        tick();
        tick();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL timeout_stay: got %0d expected 2", state); end
        n_checks++; if (stall_cnt !== 2'd3) begin n_fail++; $display("FAIL timeout_stall_sat: got %0d expected 3", stall_cnt); end
        dmem_busy = 1'b0;
        #1;
        n_checks++; if ({pc_write, ifid_write, idex_hold} !== 3'b110) begin
            n_fail++; $display("FAIL timeout_release_ctrl: got %b expected 110", {pc_write, ifid_write, idex_hold});
        end
        tick();
        n_checks++; if ({state, timeout} !== 3'b001) begin
            n_fail++; $display("FAIL timeout_sticky: got state=%0d to=%b expected state=0 to=1", state, timeout);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++; if ({timeout, stall_cnt} !== 3'b000) begin
            n_fail++; $display("FAIL timeout_clear: got to=%b stall=%0d expected to=0 stall=0", timeout, stall_cnt);
        end
    endtask

    task automatic test_saturate();
        clear_cnt();
        idex_memread = 1'b1;
        idex_rtaddr  = 5'd9;
        id_rsaddr    = 5'd9;
        tick();
        tick();
        n_checks++; if (stall_cnt !== 2'd2) begin n_fail++; $display("FAIL sat_count_2: got %0d expected 2", stall_cnt); end
        tick();
        n_checks++; if (stall_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_count_3: got %0d expected 3", stall_cnt); end
        tick();
        tick();
        n_checks++; if (stall_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d expected 3", stall_cnt); end
        // Clear coincides with a stall cycle; the clear must win.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++; if (stall_cnt !== 2'd0) begin n_fail++; $display("FAIL clear_wins: got %0d expected 0", stall_cnt); end
        set_idle();
        tick();
    endtask

    task automatic test_async_reset();
        clear_cnt();
        dmem_busy = 1'b1;
        tick();
        tick();
        n_checks++; if ({state, stall_cnt} !== 4'b0110) begin
            n_fail++; $display("FAIL areset_pre: got state=%0d stall=%0d expected state=1 stall=2", state, stall_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL areset_state: got %0d expected 0", state); end
        n_checks++; if (stall_cnt !== 2'd0) begin n_fail++; $display("FAIL areset_stall_cnt: got %0d expected 0", stall_cnt); end
        dmem_busy = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        n_checks++; if ({state, timeout, pc_write} !== 4'b0001) begin
            n_fail++; $display("FAIL areset_after: got %b expected 0001", {state, timeout, pc_write});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_ld_use();
        test_no_stall();
        test_branch_over_ld_use();
        test_busy_branch();
        test_timeout();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
